// File: rtl/wireframe_mem_arbiter_if.sv
// Rasterizer write, display read, memory and status signals of the wireframe memory arbiter.
interface wireframe_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 17
);
    logic              wr_en;
    logic              wr_data;
    logic [ADDR_W-1:0] wr_addr;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic              rd_valid;
    logic              rd_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wdata;
    logic              mem_rdata;
    logic              fifo_full;
    logic              overflow;
    logic              clr_overflow;
    logic              idle;

    // Arbiter side
    modport slave (
        input  wr_en, wr_data, wr_addr, rd_req, rd_addr, mem_rdata, clr_overflow,
        output rd_gnt, rd_valid, rd_data, mem_we, mem_addr, mem_wdata,
        output fifo_full, overflow, idle
    );

    // Requester / memory side
    modport master (
        output wr_en, wr_data, wr_addr, rd_req, rd_addr, mem_rdata, clr_overflow,
        input  rd_gnt, rd_valid, rd_data, mem_we, mem_addr, mem_wdata,
        input  fifo_full, overflow, idle
    );
endinterface

// File: rtl/wireframe_mem_arbiter.sv
// Shares one wireframe memory port between buffered rasterizer writes and
// priority display reads; a read-streak limit guarantees queued writes drain.
module wireframe_mem_arbiter #(
    parameter int unsigned ADDR_W        = 17,
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned MAX_RD_STREAK = 16
) (
    input  logic                   clk,
    input  logic                   n_rst,
    wireframe_mem_arbiter_if.slave bus
);
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned STREAK_W = $clog2(MAX_RD_STREAK + 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} slot_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              data;
    } entry_t;

    entry_t              fifo_mem [FIFO_DEPTH];
    entry_t              head;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [STREAK_W-1:0] streak;
    slot_t               state;
    slot_t               slot;
    logic                overflow_q;
    logic                empty;
    logic                full;
    logic                force_wr;
    logic                push;
    logic                pop;
    logic                drop;

    assign head     = fifo_mem[rd_ptr];
    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign force_wr = (streak == STREAK_W'(MAX_RD_STREAK)) && !empty;

    // Slot decision for the current cycle: forced write, then read, then drain.
    always_comb begin
        slot = S_IDLE;
        if (!n_rst) begin
            slot = S_IDLE;
        end else if (force_wr) begin
            slot = S_WRITE;
        end else if (bus.rd_req) begin
            slot = S_READ;
        end else if (!empty) begin
            slot = S_WRITE;
        end
    end

    assign pop  = (slot == S_WRITE);
    assign push = bus.wr_en && (!full || pop);
    assign drop = bus.wr_en && full && !pop;

    // Memory port and status outputs.
    assign bus.rd_gnt    = (slot == S_READ);
    assign bus.mem_we    = pop;
    assign bus.mem_addr  = (slot == S_READ)  ? bus.rd_addr :
                           (slot == S_WRITE) ? head.addr   : '0;
    assign bus.mem_wdata = pop && head.data;
    assign bus.rd_valid  = (state == S_READ);
    assign bus.rd_data   = bus.mem_rdata;
    assign bus.fifo_full = full;
    assign bus.overflow  = overflow_q;
    assign bus.idle      = empty && (state != S_READ);

    // Write FIFO storage; contents need no reset since count gates every use.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{addr: bus.wr_addr, data: bus.wr_data};
        end
    end

    // Slot state, read streak, FIFO pointers/count and sticky overflow.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= S_IDLE;
            streak     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state <= slot;

            if (slot == S_READ) begin
                if (streak != STREAK_W'(MAX_RD_STREAK)) begin
                    streak <= streak + STREAK_W'(1);
                end
            end else begin
                streak <= '0;
            end

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            if (drop) begin
                overflow_q <= 1'b1;
            end else if (bus.clr_overflow) begin
                overflow_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_wireframe_mem_arbiter.sv
// Self-checking bench for wireframe_mem_arbiter: vector table plus multi-cycle
// sequences, with write and read scoreboards fed as stimulus is applied.
module tb_wireframe_mem_arbiter;
    localparam int unsigned ADDR_W = 17;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              data;
    } wr_t;

    typedef struct {
        logic              we;
        logic              wd;
        logic [ADDR_W-1:0] wa;
        logic              rq;
        logic [ADDR_W-1:0] ra;
        logic              gnt;
        logic              mwe;
        logic [ADDR_W-1:0] maddr;
        logic              mwd;
        logic              rv;
        logic              idle;
    } vec_t;

    logic clk = 1'b0;
    logic n_rst;
    int   errors = 0;
    int   checks = 0;

    wr_t  wq[$];
    logic rq[$];
    logic mem_model [int];
    wr_t  mon_w;
    logic mon_r;

    always #5 clk = ~clk;

    wireframe_mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    wireframe_mem_arbiter #(
        .ADDR_W(ADDR_W),
        .FIFO_DEPTH(8),
        .MAX_RD_STREAK(16)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .bus(bus)
    );

    function automatic logic pat(input logic [ADDR_W-1:0] a);
        return a[0] ^ a[2] ^ a[5];
    endfunction

    // Synchronous-read memory behind the arbiter; unwritten cells hold pat(addr).
    always @(posedge clk) begin
        bus.mem_rdata <= mem_model.exists(int'(bus.mem_addr)) ? mem_model[int'(bus.mem_addr)]
                                                              : pat(bus.mem_addr);
        if (bus.mem_we) begin
            mem_model[int'(bus.mem_addr)] = bus.mem_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Scoreboard monitor: pops expected writes on mem_we and expected read data on rd_valid.
    always @(negedge clk) begin
        if (n_rst === 1'b1) begin
            if (bus.rd_valid) begin
                if (rq.size() == 0) begin
                    fail_now("rd_valid_unexpected");
                end else begin
                    mon_r = rq.pop_front();
                    check("rd_data", 32'(bus.rd_data), 32'(mon_r));
                end
            end
            if (bus.rd_gnt) begin
                rq.push_back(pat(bus.rd_addr));
            end
            if (bus.mem_we) begin
                if (wq.size() == 0) begin
                    fail_now("mem_we_unexpected");
                end else begin
                    mon_w = wq.pop_front();
                    check("wr_addr", 32'(bus.mem_addr), 32'(mon_w.addr));
                    check("wr_data", 32'(bus.mem_wdata), 32'(mon_w.data));
                end
            end
        end
    end

    task automatic drive(input logic we, input logic wd, input logic [ADDR_W-1:0] wa,
                         input logic rqv, input logic [ADDR_W-1:0] ra, input logic clr);
        @(posedge clk);
        #1;
        bus.wr_en        = we;
        bus.wr_data      = wd;
        bus.wr_addr      = wa;
        bus.rd_req       = rqv;
        bus.rd_addr      = ra;
        bus.clr_overflow = clr;
    endtask

    task automatic clear_inputs();
        bus.wr_en        = 1'b0;
        bus.wr_data      = 1'b0;
        bus.wr_addr      = '0;
        bus.rd_req       = 1'b0;
        bus.rd_addr      = '0;
        bus.clr_overflow = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_gnt"},    32'(bus.rd_gnt),    32'(0));
        check({tag, "_mem_we"},    32'(bus.mem_we),    32'(0));
        check({tag, "_mem_addr"},  32'(bus.mem_addr),  32'(0));
        check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'(0));
        check({tag, "_rd_valid"},  32'(bus.rd_valid),  32'(0));
        check({tag, "_overflow"},  32'(bus.overflow),  32'(0));
        check({tag, "_fifo_full"}, 32'(bus.fifo_full), 32'(0));
        check({tag, "_idle"},      32'(bus.idle),      32'(1));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        n_rst = 1'b0;
        wq.delete();
        rq.delete();
        clear_inputs();
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic drain(input string name);
        int n;
        drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        n = 0;
        while ((wq.size() != 0 || rq.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check(name, 32'(wq.size() + rq.size()), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [11];
        int   ngrant;
        logic exp_we;

        // Reset and push/drain, then read-only traffic with an empty FIFO.
        vecs[0]  = '{1'b1, 1'b1, 17'd5, 1'b0, 17'd0,   1'b0, 1'b0, 17'd0,   1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 17'd6, 1'b0, 17'd0,   1'b0, 1'b1, 17'd5,   1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 17'd7, 1'b0, 17'd0,   1'b0, 1'b1, 17'd6,   1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 17'd0, 1'b0, 17'd0,   1'b0, 1'b1, 17'd7,   1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 17'd0, 1'b0, 17'd0,   1'b0, 1'b0, 17'd0,   1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 17'd0, 1'b1, 17'd100, 1'b1, 1'b0, 17'd100, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 17'd0, 1'b1, 17'd100, 1'b1, 1'b0, 17'd100, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 17'd0, 1'b1, 17'd100, 1'b1, 1'b0, 17'd100, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 17'd0, 1'b1, 17'd100, 1'b1, 1'b0, 17'd100, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 17'd0, 1'b0, 17'd0,   1'b0, 1'b0, 17'd0,   1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 17'd0, 1'b0, 17'd0,   1'b0, 1'b0, 17'd0,   1'b0, 1'b0, 1'b1};

        // Initial reset with a pending read request that must not be granted.
        n_rst = 1'b0;
        clear_inputs();
        bus.rd_req = 1'b1;
        #12;
        check_reset_outputs("reset");
        bus.rd_req = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].we, vecs[i].wd, vecs[i].wa, vecs[i].rq, vecs[i].ra, 1'b0);
            if (vecs[i].we) wq.push_back('{addr: vecs[i].wa, data: vecs[i].wd});
            @(negedge clk);
            check($sformatf("vec%0d_rd_gnt", i),    32'(bus.rd_gnt),    32'(vecs[i].gnt));
            check($sformatf("vec%0d_mem_we", i),    32'(bus.mem_we),    32'(vecs[i].mwe));
            check($sformatf("vec%0d_mem_addr", i),  32'(bus.mem_addr),  32'(vecs[i].maddr));
            check($sformatf("vec%0d_mem_wdata", i), 32'(bus.mem_wdata), 32'(vecs[i].mwd));
            check($sformatf("vec%0d_rd_valid", i),  32'(bus.rd_valid),  32'(vecs[i].rv));
            check($sformatf("vec%0d_idle", i),      32'(bus.idle),      32'(vecs[i].idle));
        end
        drain("vec_drain");

        // Streak limit: two queued writes under continuous reads.
        do_reset();
        ngrant = 0;
        for (int c = 0; c < 36; c++) begin
            exp_we = (c == 16) || (c == 33);
            drive(1'(c < 2), 1'(c == 0), 17'(300 + c), 1'b1, 17'(2000 + ngrant), 1'b0);
            if (c < 2) wq.push_back('{addr: 17'(300 + c), data: 1'(c == 0)});
            @(negedge clk);
            check($sformatf("streak_c%0d_mem_we", c), 32'(bus.mem_we), 32'(exp_we));
            check($sformatf("streak_c%0d_rd_gnt", c), 32'(bus.rd_gnt), 32'(!exp_we));
            if (!exp_we) ngrant++;
        end
        drain("streak_drain");

        // Overflow: nine pushes into depth eight; set beats clear in the drop cycle.
        do_reset();
        for (int c = 0; c < 11; c++) begin
            drive(1'(c < 9), 1'(c & 1), 17'(400 + c), 1'(c < 9), 17'(3000 + c),
                  1'(c == 8 || c == 9));
            if (c < 8) wq.push_back('{addr: 17'(400 + c), data: 1'(c & 1)});
            @(negedge clk);
            if (c == 7) check("ovf_full_before", 32'(bus.fifo_full), 32'(0));
            if (c == 8) begin
                check("ovf_full_at8", 32'(bus.fifo_full), 32'(1));
                check("ovf_clear_before", 32'(bus.overflow), 32'(0));
            end
            if (c == 9)  check("ovf_set", 32'(bus.overflow), 32'(1));
            if (c == 10) check("ovf_cleared", 32'(bus.overflow), 32'(0));
        end
        drain("ovf_drain");

        // Full FIFO with push and pop in the same cycle.
        do_reset();
        for (int c = 0; c < 14; c++) begin
            drive(1'(c < 12), 1'((c >> 1) & 1), 17'(500 + c), 1'(c < 8), 17'(3500 + c), 1'b0);
            if (c < 12) wq.push_back('{addr: 17'(500 + c), data: 1'((c >> 1) & 1)});
            @(negedge clk);
            if (c >= 8 && c <= 12) check($sformatf("full_c%0d", c), 32'(bus.fifo_full), 32'(1));
            if (c == 13) check("full_after_pop", 32'(bus.fifo_full), 32'(0));
            if (c >= 8) begin
                check($sformatf("full_we_c%0d", c), 32'(bus.mem_we), 32'(1));
                check($sformatf("full_ovf_c%0d", c), 32'(bus.overflow), 32'(0));
            end
        end
        drain("full_drain");

        // Asynchronous reset in the middle of a drain with four entries queued.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(1'(c < 4), 1'b1, 17'(600 + c), 1'(c < 4), 17'(3800 + c), 1'b0);
            if (c < 4) wq.push_back('{addr: 17'(600 + c), data: 1'b1});
            @(negedge clk);
            if (c == 4) check("mid_we_before_reset", 32'(bus.mem_we), 32'(1));
        end
        #2;
        n_rst = 1'b0;
        wq.delete();
        rq.delete();
        clear_inputs();
        bus.rd_req = 1'b1;
        #1;
        check_reset_outputs("midrst");
        bus.rd_req = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
            @(negedge clk);
            check($sformatf("post_rst_we_c%0d", c), 32'(bus.mem_we), 32'(0));
            if (c == 0) begin
                check("post_rst_rd_valid", 32'(bus.rd_valid), 32'(0));
                check("post_rst_idle", 32'(bus.idle), 32'(1));
            end
        end
        check("final_queues", 32'(wq.size() + rq.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wireframe_mem_arbiter.md
Name: wireframe_mem_arbiter

Overview:
- Shares the single wireframe memory port between two requesters: rasterizer pixel writes (write_en/wf_data/addr) and display-scan reads.
- Rasterizer writes have no backpressure, so they are absorbed by an internal write FIFO.
- Display reads have priority. A streak limit guarantees that pending writes still drain.
- Sits between the rasterizer and the wireframe RAM. The display controller connects on the read side.

Parameters:
ADDR_W, 17, wireframe address width; matches `WIREFRAME_ADDR_SIZE at instantiation
FIFO_DEPTH, 8, write FIFO entries; power of two, at least 2
MAX_RD_STREAK, 16, consecutive read grants allowed while the FIFO is non-empty before one write slot is forced

Ports:
clk  in  1  system clock
n_rst  in  1  reset, asynchronous, active-low
wr_en  in  1  rasterizer write strobe; pushes one entry per cycle
wr_data  in  1  wireframe pixel bit
wr_addr  in  ADDR_W  pixel address
rd_req  in  1  display read request
rd_addr  in  ADDR_W  display read address
rd_gnt  out  1  combinational; read is issued to memory this cycle
rd_valid  out  1  registered; rd_data is valid
rd_data  out  1  read data (= mem_rdata)
mem_we  out  1  combinational memory write enable
mem_addr  out  ADDR_W  combinational memory address
mem_wdata  out  1  combinational memory write data
mem_rdata  in  1  synchronous-read memory data, 1-cycle latency
fifo_full  out  1  count == FIFO_DEPTH
overflow  out  1  sticky; a write was dropped
clr_overflow  in  1  clears overflow
idle  out  1  FIFO empty and no read in flight

Behaviour:
- Reset (async, n_rst=0):
  - FIFO pointers and count cleared; streak=0; state=IDLE.
  - rd_valid=0, overflow=0, fifo_full=0, idle=1.
  - mem_we=0, rd_gnt=0, mem_addr=0, mem_wdata=0.
  - Reset mid-operation discards all queued writes and any in-flight read; rd_valid is 0 on the first cycle after release.
- FIFO: circular buffer of {addr,data}, count width clog2(FIFO_DEPTH)+1. Pointers wrap from FIFO_DEPTH-1 to 0.
- Push rules:
  - Push on wr_en when not full.
  - wr_en while full and no pop this cycle: entry dropped, overflow=1 next cycle.
  - wr_en while full with a pop in the same cycle: push accepted, count unchanged.
- Pop: a pop occurs only in a write slot.
- States (registered), evaluated each cycle:
  - IDLE: no grant.
  - READ: rd_gnt=1, mem_addr=rd_addr, mem_we=0; streak++ (saturates at MAX_RD_STREAK).
  - WRITE: mem_we=1, mem_addr/mem_wdata = FIFO head, pop; streak=0.
- Slot decision, combinational in the current cycle:
  - force = (streak==MAX_RD_STREAK) && !empty.
  - force → WRITE slot with rd_gnt=0. The requester holds rd_req and rd_addr until rd_gnt.
  - else rd_req → READ.
  - else !empty → WRITE.
  - else IDLE; streak=0.
- Empty FIFO: streak never forces a slot; reads are granted every cycle.
- A write pushed in cycle t can be written no earlier than cycle t+1. There is no same-cycle bypass.
- Read/write address collision:
  - A read of an address still queued in the FIFO returns memory contents, not the queued data.
  - Ordering of writes among themselves is preserved (FIFO order).
- Read latency: rd_valid is rd_gnt delayed 1 cycle; rd_data = mem_rdata in that cycle.
- overflow:
  - Set has priority over clr_overflow in the same cycle.
  - Cleared only by clr_overflow or reset.
- idle = empty && !rd_valid_pending, where rd_valid_pending = rd_gnt last cycle.

Test Plan:
1. Reset then 3 pushes (addr 5,6,7, data 1,0,1), rd_req=0 → mem_we high on cycles 1-3 after the first push, addresses 5,6,7 in order; idle=1 afterward.
2. Read only: rd_req=1, rd_addr=100 for 4 cycles, FIFO empty → rd_gnt=1 every cycle; rd_valid follows 1 cycle later; rd_data matches the memory model; streak never forces.
3. Streak limit: preload 2 writes, hold rd_req=1 → 16 read grants, then 1 forced write (rd_gnt=0, mem_we=1), then 16 reads, then a second forced write.
4. Overflow: hold rd_req=1 with MAX_RD_STREAK large and push 9 writes into depth 8 → fifo_full after 8, overflow=1 after the 9th; clr_overflow=1 → overflow=0.
5. Full with simultaneous push and pop: FIFO full, rd_req=0, wr_en=1 → count stays 8, no overflow; the written sequence preserves order with no dropped entry.
6. Async reset mid-drain with 4 entries queued → all outputs return to reset values immediately; no further mem_we after release.
